// File: rtl/vga_timing_driver.sv
// 1280x1024@60 raster timing: hsync, vsync, data-enable.
// Ports: vga_clk/sys_rst_n in, pixel_data in; xpos/ypos, hs/vs/de, rgb, frame_start out.
module vga_timing_driver #(
  parameter int   H_SYNC   = 112,
  parameter int   H_BACK   = 248,
  parameter int   H_DISP   = 1280,
  parameter int   H_FRONT  = 48,
  parameter int   V_SYNC   = 3,
  parameter int   V_BACK   = 38,
  parameter int   V_DISP   = 1024,
  parameter int   V_FRONT  = 1,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SEND = 11'(H_SYNC);
  localparam logic [10:0] V_SEND = 11'(V_SYNC);
  localparam logic [10:0] H_AS   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_AE   = 11'(H_SYNC + H_BACK + H_DISP);
  localparam logic [10:0] V_AS   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_AE   = 11'(V_SYNC + V_BACK + V_DISP);
  // request window runs one clock ahead of the active window
  localparam logic [10:0] H_RS   = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] H_RE   = 11'(H_SYNC + H_BACK + H_DISP - 1);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        h_end;
  logic        v_end;
  logic        h_act;
  logic        v_act;
  logic        data_req;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      // lands together with the wrap to (0,0)
      frame_start <= h_end && v_end;
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign vga_hs = (h_cnt < H_SEND) ? SYNC_POL : ~SYNC_POL;
  assign vga_vs = (v_cnt < V_SEND) ? SYNC_POL : ~SYNC_POL;

  assign h_act  = (h_cnt >= H_AS) && (h_cnt < H_AE);
  assign v_act  = (v_cnt >= V_AS) && (v_cnt < V_AE);
  assign vga_de = h_act && v_act;

  assign data_req = (h_cnt >= H_RS) && (h_cnt < H_RE) && v_act;

  assign pixel_xpos = data_req ? h_cnt - H_RS : 11'd0;
  assign pixel_ypos = data_req ? v_cnt - V_AS : 11'd0;

  assign vga_rgb = vga_de ? pixel_data : 24'h000000;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver: default-H/short-V and tiny builds.
// Checks reset, sync widths, DE window, pixel pipeline, frame_start, mid-line reset.
module tb_vga_timing_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] pd_h, pd_s;
  logic [10:0] xpos_h, ypos_h, xpos_s, ypos_s;
  logic        hs_h, vs_h, de_h, fs_h;
  logic        hs_s, vs_s, de_s, fs_s;
  logic [23:0] rgb_h, rgb_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_driver #(
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
  ) dut_h (
    .vga_clk(clk), .sys_rst_n(rst_n), .pixel_data(pd_h),
    .pixel_xpos(xpos_h), .pixel_ypos(ypos_h),
    .vga_hs(hs_h), .vga_vs(vs_h), .vga_de(de_h),
    .vga_rgb(rgb_h), .frame_start(fs_h)
  );

  vga_timing_driver #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .SYNC_POL(1'b0)
  ) dut_s (
    .vga_clk(clk), .sys_rst_n(rst_n), .pixel_data(pd_s),
    .pixel_xpos(xpos_s), .pixel_ypos(ypos_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_de(de_s),
    .vga_rgb(rgb_s), .frame_start(fs_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  localparam int HT = 1688;
  localparam int FH = 1688 * 7;
  localparam int FS = 98;
  localparam int T  = 23640;

  int hh, vh, hs2, vs2, n;
  int nhs_h, nvs_h, nde_h, sx_h, sy_h, nbl_h, fde_h, nfs_h, fs1_h, fs2_h;
  int nhs_s, nvs_s, nde_s, sx_s, sy_s, nbl_s, fde_s, nfs_s, fs1_s;
  int lfs_s, gap_s;

  initial begin
    {nhs_h, nvs_h, nde_h, sx_h, sy_h, nbl_h, nfs_h, fs1_h, fs2_h} = '0;
    {nhs_s, nvs_s, nde_s, sx_s, sy_s, nbl_s, nfs_s, fs1_s} = '0;
    lfs_s = 0; gap_s = 0;
    fde_h = -1; fde_s = -1;
    rst_n = 1'b0;
    pd_h  = 24'hffffff;
    pd_s  = 24'hffffff;
    repeat (5) @(negedge clk);

    chk("rst_hs_h", hs_h, 1);
    chk("rst_vs_h", vs_h, 1);
    chk("rst_de_h", de_h, 0);
    chk("rst_rgb_h", rgb_h, 0);
    chk("rst_x_h", xpos_h, 0);
    chk("rst_y_h", ypos_h, 0);
    chk("rst_fs_h", fs_h, 0);
    chk("rst_hs_s", hs_s, 0);
    chk("rst_vs_s", vs_s, 0);
    chk("rst_rgb_s", rgb_s, 0);

    rst_n = 1'b1;
    for (int t = 0; t < T; t++) begin
      hh  = t % HT;
      vh  = (t / HT) % 7;
      hs2 = t % 14;
      vs2 = (t / 14) % 7;

      if (t < FH) begin
        if (hs_h) nhs_h++;
        if (vs_h) nvs_h++;
        if (de_h) nde_h++;
        sx_h += int'(xpos_h);
        sy_h += int'(ypos_h);
        if (!de_h && rgb_h != 0) nbl_h++;
      end
      if (t < FS) begin
        if (!hs_s) nhs_s++;
        if (!vs_s) nvs_s++;
        if (de_s) nde_s++;
        sx_s += int'(xpos_s);
        sy_s += int'(ypos_s);
        if (!de_s && rgb_s != 0) nbl_s++;
      end
      if (de_h && fde_h < 0) fde_h = t;
      if (de_s && fde_s < 0) fde_s = t;

      if (de_h)
        chk("rgb_h", rgb_h, {2'b11, 11'(vh - 2), 11'(hh - 360)});
      if (de_s)
        chk("rgb_s", rgb_s, {2'b11, 11'(vs2 - 2), 11'(hs2 - 4)});

      if (fs_h) begin
        nfs_h++;
        if (nfs_h == 1) fs1_h = t;
        else if (nfs_h == 2) fs2_h = t;
      end
      if (fs_s) begin
        if (nfs_s == 0) fs1_s = t;
        else if (t - lfs_s != FS) gap_s++;
        lfs_s = t;
        nfs_s++;
      end

      if (t == 1) chk("hcnt1_hs_s", hs_s, 0);
      if (t == 2) chk("hcnt2_hs_s", hs_s, 1);
      if (t == 3376 + 359) chk("lead_x_h", xpos_h, 0);
      if (t == 3376 + 359) chk("lead_de_h", de_h, 0);
      if (t == 3376 + 360) chk("x1_h", xpos_h, 1);
      if (t == 3376 + 1638) chk("xlast_h", xpos_h, 1279);
      if (t == 3376 + 1639) chk("delast_h", de_h, 1);
      if (t == 3376 + 1639) chk("xoff_h", xpos_h, 0);
      if (t == 3376 + 1640) chk("defall_h", de_h, 0);
      if (t == 38) chk("xlast_s", xpos_s, 7);
      if (t == 39) chk("delast_s", de_s, 1);
      if (t == 40) chk("defall_s", de_s, 0);

      pd_h = {2'b11, ypos_h, xpos_h};
      pd_s = {2'b11, ypos_s, xpos_s};
      @(negedge clk);
    end

    chk("hs_width_h", nhs_h, 112 * 7);
    chk("vs_width_h", nvs_h, HT);
    chk("de_count_h", nde_h, 1280 * 4);
    chk("xsum_h", sx_h, 4 * 818560);
    chk("ysum_h", sy_h, 1280 * 6);
    chk("blank_h", nbl_h, 0);
    chk("de_first_h", fde_h, 2 * HT + 360);
    chk("fs_count_h", nfs_h, 2);
    chk("fs_first_h", fs1_h, FH);
    chk("fs_second_h", fs2_h, 2 * FH);
    chk("hs_width_s", nhs_s, 14);
    chk("vs_width_s", nvs_s, 14);
    chk("de_count_s", nde_s, 32);
    chk("xsum_s", sx_s, 112);
    chk("ysum_s", sy_s, 48);
    chk("blank_s", nbl_s, 0);
    chk("de_first_s", fde_s, 32);
    chk("fs_first_s", fs1_s, FS);
    chk("fs_gap_s", gap_s, 0);
    chk("fs_count_s", nfs_s, (T - 1) / FS);

    repeat (17 * HT + 800 - T) @(negedge clk);
    chk("pre_rst_de_h", de_h, 1);
    chk("pre_rst_x_h", xpos_h, 441);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_de_h", de_h, 0);
    chk("arst_hs_h", hs_h, 1);
    chk("arst_vs_h", vs_h, 1);
    chk("arst_x_h", xpos_h, 0);
    chk("arst_y_h", ypos_h, 0);
    chk("arst_rgb_h", rgb_h, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!de_h && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_de_rise_h", n, 2 * HT + 360);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
